// File: rtl/mult_seq_param.sv
// Sequential shift-and-add unsigned multiplier, one partial product per clock.
// Optional build macro MULT_SEQ_EARLY_TERM_EN stops iterating once the remaining multiplier bits are all zero.
module mult_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               zero,
  output logic [1:0]         state_dbg
);

  // Handshake: start is accepted only when busy=0; operands are captured on that
  // edge. busy stays high through RUN and DONE, done pulses for the single DONE cycle.
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [2*WIDTH-1:0] a_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   b_q;
  logic [CW-1:0]      cnt_q;

  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   b_next;
  logic [CW-1:0]      cnt_next;
  logic               last_iter;

  always_comb begin
    acc_next = acc_q + (b_q[0] ? a_q : '0);
    b_next   = b_q >> 1;
    cnt_next = cnt_q - 1'b1;
`ifdef MULT_SEQ_EARLY_TERM_EN
    last_iter = (b_next == '0) || (cnt_next == '0);
`else
    last_iter = (cnt_next == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      product <= '0;
      zero    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= {{WIDTH{1'b0}}, multiplicand};
            b_q   <= multiplier;
            acc_q <= '0;
            cnt_q <= CW'(WIDTH);
            state <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_next;
          a_q   <= a_q << 1;
          b_q   <= b_next;
          cnt_q <= cnt_next;
          if (last_iter) begin
            // Result and flag are committed on the same edge that enters DONE.
            product <= acc_next;
            zero    <= (acc_next == '0);
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: doc/mult_seq_param.md
MULT_SEQ_PARAM -- requirements
Module: mult_seq_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin a multiplication, sampled only in IDLE.
REQ-005 SHALL have port multiplicand  input  WIDTH  unsigned operand A, sampled with accepted start.
REQ-006 SHALL have port multiplier  input  WIDTH  unsigned operand B, sampled with accepted start.
REQ-007 SHALL have port busy  output  1  high while a multiplication is in progress (RUN or DONE).
REQ-008 SHALL have port done  output  1  one-cycle pulse marking product valid and newly updated.
REQ-009 SHALL have port product  output  2*WIDTH  registered result, held until next completion.
REQ-010 SHALL have port zero  output  1  registered flag, high when product equals 0.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE on last iteration, DONE->IDLE unconditionally.
REQ-012 SHALL, on edge with state IDLE and start=1: load A register (2*WIDTH, zero-extended multiplicand), B register (multiplier), accumulator 0, iteration counter WIDTH.
REQ-013 SHALL, on each RUN edge: if B[0]=1 add A to accumulator (2*WIDTH, no overflow possible); shift A left 1; shift B right 1; decrement counter.
REQ-014 SHALL leave RUN on the edge where the counter reaches 0 (exactly WIDTH iterations), writing the final accumulator to product and the zero flag in that same edge.
REQ-015 SHALL assert done only in DONE state: high for exactly one cycle, product valid during it.
REQ-016 SHALL give fixed latency: start sampled at edge N -> done high in cycle after edge N+WIDTH; next start accepted at edge N+WIDTH+2.
REQ-017 SHALL assert busy in RUN and DONE, deasserted in IDLE.
REQ-018 SHALL ignore start while busy=1; operand changes during RUN/DONE have no effect.
REQ-019 SHALL hold product and zero unchanged from prior completion until the next RUN->DONE edge.
REQ-020 SHALL treat operand value 0 normally: full latency, product 0, zero=1.
REQ-021 SHALL produce the exact unsigned product for all operand pairs, incl. (2^WIDTH-1)^2.

Reset
REQ-022 SHALL, on any edge with rst_n=0, enter IDLE and set busy=0, done=0, product=0, zero=1, all internal registers 0; start on that edge is ignored.
REQ-023 SHALL abandon an in-progress multiplication on reset with no done pulse; product stays 0.
REQ-024 SHALL accept start on the first edge with rst_n=1.

Configuration
REQ-025 SHALL support macro MULT_SEQ_EARLY_TERM_EN.
REQ-026 SHALL, with MULT_SEQ_EARLY_TERM_EN defined, leave RUN on the first RUN edge whose shifted B value is 0 or the counter reaches 0, whichever is first; latency = index of highest set multiplier bit + 1 iterations (1 iteration for multiplier 0 or 1).
REQ-027 SHALL, without MULT_SEQ_EARLY_TERM_EN, use the fixed WIDTH-iteration latency of REQ-016; results identical in both builds.

Verification
REQ-028 SHALL cover WIDTH=8, start with A=3, B=5 at edge N -> done one cycle after edge N+8, product=15, zero=0, busy low from edge N+10.
REQ-029 SHALL cover WIDTH=8, A=255, B=255 -> product=65025; WIDTH=16, A=B=65535 -> product=0xFFFE0001.
REQ-030 SHALL cover A=200, B=0 -> product=0, zero=1, single done pulse, full latency (macro off).
REQ-031 SHALL cover start re-asserted with A=7, B=9 during RUN of 3*5 -> ignored, product=15, only one done pulse.
REQ-032 SHALL cover rst_n=0 at iteration 4 of 3*5 -> next cycle busy=0, done=0, product=0, zero=1; no done pulse; then 6*7 -> 42.
REQ-033 SHALL cover macro on, WIDTH=8: B=1 -> done one cycle after edge N+1; B=0x80 -> one cycle after edge N+8; products match macro-off build.
